// File: rtl/cm0ik_rst_seq_pkg.sv
// Shared types, default parameter values and width helpers for the reset sequencer.
package cm0ik_rst_seq_pkg;

  localparam int unsigned DEF_NUM_CH  = 3;
  localparam int unsigned DEF_POR_LEN = 3;
  localparam int unsigned DEF_SYS_LEN = 3;
  localparam int unsigned DEF_STAGGER = 2;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_WARM    = 2'd3
  } state_t;

  // Counter width large enough to hold the longest phase length.
  function automatic int unsigned cnt_width(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cm0ik_rst_seq_if.sv
// Clock-status / warm-reset inputs and per-domain reset outputs of the sequencer.
interface cm0ik_rst_seq_if
  import cm0ik_rst_seq_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH
);
  logic              CLKLOCK;
  logic              SYSRESETREQ;
  logic              SYSRESETREQEN;
  logic              LOCKUP;
  logic              LOCKUPRESET;
  logic [NUM_CH-1:0] RSTn;
  logic              RST_DONE;
  logic              SYSRESETACK;

  modport master (
    input  CLKLOCK, SYSRESETREQ, SYSRESETREQEN, LOCKUP, LOCKUPRESET,
    output RSTn, RST_DONE, SYSRESETACK
  );

  modport slave (
    output CLKLOCK, SYSRESETREQ, SYSRESETREQEN, LOCKUP, LOCKUPRESET,
    input  RSTn, RST_DONE, SYSRESETACK
  );
endinterface

// File: rtl/cm0ik_rst_seq_cnt.sv
// Clear/enable up-counter with terminal-count compare, shared by all timed phases.
module cm0ik_rst_seq_cnt #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] tc_val,
  output logic             tc_c
);
  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

  assign tc_c = (cnt == tc_val);

endmodule

// File: rtl/cm0ik_rst_seq.sv
// Parametrised reset sequencer: PLL-gated power-on release, staggered per-domain
// deassertion and warm (SYSRESETREQ / LOCKUP) re-assertion of the system domains.
module cm0ik_rst_seq
  import cm0ik_rst_seq_pkg::*;
#(
  parameter int unsigned NUM_CH  = DEF_NUM_CH,
  parameter int unsigned POR_LEN = DEF_POR_LEN,
  parameter int unsigned SYS_LEN = DEF_SYS_LEN,
  parameter int unsigned STAGGER = DEF_STAGGER
) (
  input logic             FCLK,
  input logic             PORESET,
  cm0ik_rst_seq_if.master bus
);
  localparam int unsigned CW = cnt_width(POR_LEN, SYS_LEN, STAGGER);
  localparam int unsigned IW = $clog2(NUM_CH + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CH - 1);

  state_t            state, state_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic [NUM_CH-1:0] rstn, rstn_nxt;
  logic              done, done_nxt;
  logic              ack, ack_nxt;
  logic [CW-1:0]     tc_val_c;
  logic              tc_c, cnt_clr_c, cnt_en_c, wreq_c;

  assign wreq_c = (bus.SYSRESETREQ & bus.SYSRESETREQEN) | (bus.LOCKUP & bus.LOCKUPRESET);

  cm0ik_rst_seq_cnt #(.WIDTH(CW)) u_cnt (
    .clk    (FCLK),
    .rst    (PORESET),
    .clr    (cnt_clr_c),
    .en     (cnt_en_c),
    .tc_val (tc_val_c),
    .tc_c   (tc_c)
  );

  always_ff @(posedge FCLK) begin
    if (PORESET) begin
      state <= ST_ASSERT;
      idx   <= '0;
      rstn  <= '0;
      done  <= 1'b0;
      ack   <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      rstn  <= rstn_nxt;
      done  <= done_nxt;
      ack   <= ack_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    rstn_nxt  = rstn;
    done_nxt  = done;
    ack_nxt   = 1'b0;
    cnt_clr_c = 1'b0;
    cnt_en_c  = 1'b0;
    tc_val_c  = CW'(POR_LEN - 1);

    // Losing PLL lock outranks everything except PORESET: drop every domain.
    if (state != ST_ASSERT && !bus.CLKLOCK) begin
      rstn_nxt  = '0;
      done_nxt  = 1'b0;
      idx_nxt   = '0;
      cnt_clr_c = 1'b1;
      state_nxt = ST_ASSERT;
    end else begin
      case (state)
        ST_ASSERT: begin
          rstn_nxt = '0;
          done_nxt = 1'b0;
          if (!bus.CLKLOCK) begin
            cnt_clr_c = 1'b1;
          end else if (tc_c) begin
            rstn_nxt[0] = 1'b1;
            cnt_clr_c   = 1'b1;
            idx_nxt     = IW'(1);
            if (NUM_CH == 1) begin
              done_nxt  = 1'b1;
              state_nxt = ST_RUN;
            end else begin
              state_nxt = ST_RELEASE;
            end
          end else begin
            cnt_en_c = 1'b1;
          end
        end

        ST_RELEASE: begin
          tc_val_c = CW'(STAGGER - 1);
          if (tc_c) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
              if (IW'(i) == idx) rstn_nxt[i] = 1'b1;
            end
            cnt_clr_c = 1'b1;
            idx_nxt   = idx + IW'(1);
            if (idx == LAST_IDX) begin
              done_nxt  = 1'b1;
              state_nxt = ST_RUN;
            end
          end else begin
            cnt_en_c = 1'b1;
          end
        end

        ST_RUN: begin
          if (wreq_c) begin
            ack_nxt = 1'b1;
            if (NUM_CH > 1) begin
              for (int unsigned i = 1; i < NUM_CH; i++) rstn_nxt[i] = 1'b0;
              done_nxt  = 1'b0;
              cnt_clr_c = 1'b1;
              state_nxt = ST_WARM;
            end
          end
        end

        ST_WARM: begin
          tc_val_c = CW'(SYS_LEN - 1);
          if (tc_c) begin
            for (int unsigned i = 1; i < NUM_CH; i++) begin
              if (i == 1) rstn_nxt[i] = 1'b1;
            end
            cnt_clr_c = 1'b1;
            idx_nxt   = IW'(2);
            if (NUM_CH == 2) begin
              done_nxt  = 1'b1;
              state_nxt = ST_RUN;
            end else begin
              state_nxt = ST_RELEASE;
            end
          end else begin
            cnt_en_c = 1'b1;
          end
        end

        default: state_nxt = ST_ASSERT;
      endcase
    end
  end

  assign bus.RSTn        = rstn;
  assign bus.RST_DONE    = done;
  assign bus.SYSRESETACK = ack;

endmodule

// File: tb/tb_cm0ik_rst_seq.sv
// Bench for cm0ik_rst_seq: three builds (3ch/stagger 2, 1ch, 3ch/stagger 1) share one
// stimulus; a closed-form release-time model is compared every cycle plus literal checks.
module tb_cm0ik_rst_seq;

  logic clk = 1'b0;
  logic prst, clklock, sreq, sreqen, lockup, lockupen;
  logic wreq;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   chk_en   = 1'b0;

  always #5 clk = ~clk;

  assign wreq = (sreq & sreqen) | (lockup & lockupen);

  cm0ik_rst_seq_if #(.NUM_CH(3)) if_a ();
  cm0ik_rst_seq_if #(.NUM_CH(1)) if_b ();
  cm0ik_rst_seq_if #(.NUM_CH(3)) if_c ();

  assign if_a.CLKLOCK = clklock; assign if_a.SYSRESETREQ = sreq; assign if_a.SYSRESETREQEN = sreqen;
  assign if_a.LOCKUP  = lockup;  assign if_a.LOCKUPRESET = lockupen;
  assign if_b.CLKLOCK = clklock; assign if_b.SYSRESETREQ = sreq; assign if_b.SYSRESETREQEN = sreqen;
  assign if_b.LOCKUP  = lockup;  assign if_b.LOCKUPRESET = lockupen;
  assign if_c.CLKLOCK = clklock; assign if_c.SYSRESETREQ = sreq; assign if_c.SYSRESETREQEN = sreqen;
  assign if_c.LOCKUP  = lockup;  assign if_c.LOCKUPRESET = lockupen;

  cm0ik_rst_seq #(.NUM_CH(3), .POR_LEN(3), .SYS_LEN(3), .STAGGER(2)) dut_a (
    .FCLK(clk), .PORESET(prst), .bus(if_a.master));
  cm0ik_rst_seq #(.NUM_CH(1), .POR_LEN(3), .SYS_LEN(3), .STAGGER(2)) dut_b (
    .FCLK(clk), .PORESET(prst), .bus(if_b.master));
  cm0ik_rst_seq #(.NUM_CH(3), .POR_LEN(3), .SYS_LEN(3), .STAGGER(1)) dut_c (
    .FCLK(clk), .PORESET(prst), .bus(if_c.master));

  // Model: a sequence starts at edge s; channel i >= f rises at s + d - 1 + (i - f) * stagger,
  // channels below f are already up (warm sequences keep ch0 released).
  typedef struct packed {
    bit         waiting;
    int         s;
    int         f;
    int         d;
    logic [7:0] rstn;
    bit         done;
    bit         ack;
  } mdl_t;

  mdl_t mdl_a, mdl_b, mdl_c;

  function automatic mdl_t mstep(mdl_t m, int n, int nch, int por, int sys, int stg,
                                 logic p, logic lock, logic wr);
    mdl_t r;
    r = m;
    r.ack = 1'b0;
    if (p || !lock) begin
      r.waiting = 1'b1;
      r.rstn    = '0;
      r.done    = 1'b0;
      return r;
    end
    if (m.waiting) begin
      r.waiting = 1'b0;
      r.s = n; r.f = 0; r.d = por;
    end else if (m.done && wr) begin
      r.ack = 1'b1;
      if (nch > 1) begin
        r.s = n + 1; r.f = 1; r.d = sys;
      end
    end
    r.rstn = '0;
    for (int i = 0; i < nch; i++) begin
      if (i < r.f || n >= r.s + r.d - 1 + (i - r.f) * stg) r.rstn[i] = 1'b1;
    end
    r.done = (r.rstn == 8'((1 << nch) - 1));
    return r;
  endfunction

  always @(posedge clk) begin
    mdl_a <= mstep(mdl_a, cyc, 3, 3, 3, 2, prst, clklock, wreq);
    mdl_b <= mstep(mdl_b, cyc, 1, 3, 3, 2, prst, clklock, wreq);
    mdl_c <= mstep(mdl_c, cyc, 3, 3, 3, 1, prst, clklock, wreq);
    cyc   <= cyc + 1;
  end

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("a_rstn", 8'(if_a.RSTn), mdl_a.rstn);
      check("a_done", 8'(if_a.RST_DONE), 8'(mdl_a.done));
      check("a_ack",  8'(if_a.SYSRESETACK), 8'(mdl_a.ack));
      check("b_rstn", 8'(if_b.RSTn), mdl_b.rstn);
      check("b_done", 8'(if_b.RST_DONE), 8'(mdl_b.done));
      check("b_ack",  8'(if_b.SYSRESETACK), 8'(mdl_b.ack));
      check("c_rstn", 8'(if_c.RSTn), mdl_c.rstn);
      check("c_done", 8'(if_c.RST_DONE), 8'(mdl_c.done));
      check("c_ack",  8'(if_c.SYSRESETACK), 8'(mdl_c.ack));
    end
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    prst = 1'b1; clklock = 1'b1;
    sreq = 1'b0; sreqen = 1'b0; lockup = 1'b0; lockupen = 1'b0;

    // PORESET held for four edges with the clock locked.
    step(1);
    chk_en = 1'b1;
    step(3);
    check("lit_reset_rstn", 8'(if_a.RSTn), 8'b000);
    check("lit_reset_done", 8'(if_a.RST_DONE), 8'd0);
    prst = 1'b0;
    step(2);  check("lit_e2_rstn", 8'(if_a.RSTn), 8'b000);
    step(1);  check("lit_e3_rstn", 8'(if_a.RSTn), 8'b001);
              check("lit_b_e3_rstn", 8'(if_b.RSTn), 8'b1);
              check("lit_b_e3_done", 8'(if_b.RST_DONE), 8'd1);
    step(1);  check("lit_e4_rstn", 8'(if_a.RSTn), 8'b001);
              check("lit_c_e4_rstn", 8'(if_c.RSTn), 8'b011);
    step(1);  check("lit_e5_rstn", 8'(if_a.RSTn), 8'b011);
              check("lit_c_e5_rstn", 8'(if_c.RSTn), 8'b111);
    step(1);  check("lit_e6_done", 8'(if_a.RST_DONE), 8'd0);
    step(1);  check("lit_e7_rstn", 8'(if_a.RSTn), 8'b111);
              check("lit_e7_done", 8'(if_a.RST_DONE), 8'd1);

    // Enabled SYSRESETREQ for one cycle.
    sreq = 1'b1; sreqen = 1'b1;
    step(1);  check("lit_warm_ack", 8'(if_a.SYSRESETACK), 8'd1);
              check("lit_warm_rstn0", 8'(if_a.RSTn), 8'b001);
              check("lit_b_warm_ack", 8'(if_b.SYSRESETACK), 8'd1);
    sreq = 1'b0;
    step(1);  check("lit_warm_ack_off", 8'(if_a.SYSRESETACK), 8'd0);
    step(1);  check("lit_warm_rstn2", 8'(if_a.RSTn), 8'b001);
    step(1);  check("lit_warm_rstn3", 8'(if_a.RSTn), 8'b011);
    step(2);  check("lit_warm_rstn5", 8'(if_a.RSTn), 8'b111);
              check("lit_warm_done5", 8'(if_a.RST_DONE), 8'd1);

    // Disabled sources must be ignored, then LOCKUP with its enable.
    sreq = 1'b1; sreqen = 1'b0; lockup = 1'b1; lockupen = 1'b0;
    step(4);  check("lit_dis_rstn", 8'(if_a.RSTn), 8'b111);
              check("lit_dis_ack", 8'(if_a.SYSRESETACK), 8'd0);
    lockupen = 1'b1;
    step(1);  check("lit_lockup_ack", 8'(if_a.SYSRESETACK), 8'd1);
              check("lit_lockup_rstn", 8'(if_a.RSTn), 8'b001);
    lockupen = 1'b0; lockup = 1'b0; sreq = 1'b0;
    step(6);  check("lit_lockup_back", 8'(if_a.RSTn), 8'b111);

    // Lock lost during the staggered warm release while a request is pending.
    sreq = 1'b1; sreqen = 1'b1;
    step(1);
    sreq = 1'b0;
    step(3);  check("lit_pre_loss_rstn", 8'(if_a.RSTn), 8'b011);
    clklock = 1'b0; sreq = 1'b1;
    step(1);  check("lit_loss_rstn", 8'(if_a.RSTn), 8'b000);
              check("lit_loss_ack", 8'(if_a.SYSRESETACK), 8'd0);
    step(9);  check("lit_nolock_rstn", 8'(if_a.RSTn), 8'b000);
    clklock = 1'b1;
    step(2);  check("lit_l2_rstn", 8'(if_a.RSTn), 8'b000);
    step(1);  check("lit_l3_rstn", 8'(if_a.RSTn), 8'b001);
    step(2);  check("lit_l5_rstn", 8'(if_a.RSTn), 8'b011);
    step(2);  check("lit_l7_rstn", 8'(if_a.RSTn), 8'b111);
              check("lit_l7_ack", 8'(if_a.SYSRESETACK), 8'd0);
    step(1);  check("lit_retrig_ack", 8'(if_a.SYSRESETACK), 8'd1);
              check("lit_retrig_rstn", 8'(if_a.RSTn), 8'b001);
    sreq = 1'b0;
    step(6);

    // PORESET during the warm hold restarts the whole power-on sequence.
    sreq = 1'b1;
    step(1);
    sreq = 1'b0;
    step(1);  check("lit_inwarm_rstn", 8'(if_a.RSTn), 8'b001);
    prst = 1'b1;
    step(1);  check("lit_midrst_rstn", 8'(if_a.RSTn), 8'b000);
              check("lit_midrst_done", 8'(if_a.RST_DONE), 8'd0);
    prst = 1'b0;
    step(3);  check("lit_restart_rstn", 8'(if_a.RSTn), 8'b001);
    step(10); check("lit_final_done", 8'(if_a.RST_DONE), 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
